// File: rtl/led_pixel_feeder.sv
// Frame buffer and pixel sequencer feeding a WS2812 string driver: holds NUM_LEDS colours,
// streams them on pix_req, then idles GAP_CYCLES for the latch. Option: AUTO_REFRESH_EN.
module led_pixel_feeder #(
  parameter  int NUM_LEDS   = 8,
  parameter  int GAP_CYCLES = 3000,
  localparam int IDX_W      = $clog2(NUM_LEDS),
  localparam int CNT_W      = $clog2(GAP_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [23:0]      wr_data,
  input  logic             frame_start,
  input  logic             pix_req,
  output logic [23:0]      rgb,
  output logic             pix_valid,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_rgb;
  logic             r_pix_valid;
  logic             r_busy;
  logic             r_frame_done;
  logic [23:0]      r_mem [NUM_LEDS];

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [23:0]      w_rgb_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_addr_ok;
  logic             w_last;
  logic             w_cnt_zero;

  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_addr_ok  = ({1'b0, wr_addr} < (IDX_W+1)'(NUM_LEDS));
  assign w_last     = (r_idx == IDX_W'(NUM_LEDS - 1));
  assign w_cnt_zero = (r_cnt == CNT_W'(0));

  // Colour memory; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_mem[i] <= 24'h0;
      end
    end else if (wr_en && w_addr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_rgb_nxt   = r_rgb;
    w_valid_nxt = r_pix_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The frame_done cycle is still part of the finished frame, so a start there is dropped.
        if (frame_start && !r_frame_done) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = IDX_W'(0);
          w_rgb_nxt   = r_mem[0];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (pix_req && w_last) begin
          w_state_nxt = ST_GAP;
          w_rgb_nxt   = 24'h0;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
        end else if (pix_req) begin
          w_idx_nxt = w_idx_inc;
          // A write landing on the next pixel in this same cycle must not be missed.
          if (wr_en && (wr_addr == w_idx_inc)) begin
            w_rgb_nxt = wr_data;
          end else begin
            w_rgb_nxt = r_mem[w_idx_inc];
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          w_done_nxt = 1'b1;
`ifdef AUTO_REFRESH_EN
          w_state_nxt = ST_SEND;
          w_idx_nxt   = IDX_W'(0);
          w_rgb_nxt   = r_mem[0];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
`else
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = IDX_W'(0);
        w_cnt_nxt   = CNT_W'(0);
        w_rgb_nxt   = 24'h0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= IDX_W'(0);
      r_cnt        <= CNT_W'(0);
      r_rgb        <= 24'h0;
      r_pix_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rgb        <= w_rgb_nxt;
      r_pix_valid  <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign rgb        = r_rgb;
  assign pix_valid  = r_pix_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_pixel_feeder.sv
// Randomized bench for led_pixel_feeder against a frame-level model (pixel array + timing rules).
// Five pixels so that out-of-range addresses fit on the 3-bit wr_addr.
module tb_led_pixel_feeder;
  localparam int NUM = 5;
  localparam int GAP = 10;
  localparam int IW  = $clog2(NUM);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          frame_start;
  logic          pix_req;
  logic [23:0]   rgb;
  logic          pix_valid;
  logic          busy;
  logic          frame_done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] model_mem [NUM];

  always #5 clk = ~clk;

  led_pixel_feeder #(.NUM_LEDS(NUM), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .pix_req(pix_req), .rgb(rgb), .pix_valid(pix_valid),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int addr, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = IW'(addr); wr_data = d;
    cyc();
    wr_en = 1'b0;
    if (addr < NUM) model_mem[addr] = d;
  endtask

  task automatic fill_random();
    for (int a = 0; a < NUM; a++) drive_write(a, 24'($urandom));
  endtask

  // Full frame from IDLE; with stress, GAP is peppered with ignored pix_req/frame_start.
  task automatic send_frame(input bit stress, input string tag);
    int k;
    int w;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    for (int p = 0; p < NUM; p++) begin
      n_vec++;
      if (rgb !== model_mem[p] || pix_valid !== 1'b1 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s pix%0d got rgb=%h v=%b b=%b exp rgb=%h v=1 b=1", tag, p, rgb, pix_valid, busy, model_mem[p]);
      end
      w = $urandom_range(0, 30);
      for (int i = 0; i < w; i++) begin
        cyc();
        n_vec++;
        if (rgb !== model_mem[p]) begin
          n_err++;
          $display("FAIL %s hold%0d got rgb=%h exp %h", tag, p, rgb, model_mem[p]);
        end
      end
      pix_req = 1'b1; cyc(); pix_req = 1'b0;
    end
    n_vec++;
    if (rgb !== 24'h0 || pix_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s gap_entry got rgb=%h v=%b b=%b exp 0/0/1", tag, rgb, pix_valid, busy);
    end
    k = 0;
    while (!frame_done && k < GAP + 20) begin
      if (stress) begin
        pix_req = 1'($urandom_range(0, 1));
        frame_start = 1'($urandom_range(0, 1));
      end
      cyc();
      k++;
      if (!frame_done) begin
        n_vec++;
        if (rgb !== 24'h0 || pix_valid !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s gap_hold got rgb=%h v=%b b=%b exp 0/0/1", tag, rgb, pix_valid, busy);
        end
      end
    end
    n_vec++;
    if (k != GAP || frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_latency got %0d cycles (done=%b) exp %0d", tag, k, frame_done, GAP);
    end
    if (stress) begin
      frame_start = 1'b1; pix_req = 1'b1;
    end
    cyc();
    frame_start = 1'b0; pix_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s after_done got d=%b b=%b v=%b exp 0/0/0", tag, frame_done, busy, pix_valid);
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 24'h0; frame_start = 1'b0; pix_req = 1'b0;
    for (int a = 0; a < NUM; a++) model_mem[a] = 24'h0;
    repeat (3) cyc();
    n_vec++;
    if ({rgb, pix_valid, busy, frame_done} !== 27'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %h exp 0", {rgb, pix_valid, busy, frame_done});
    end
    rst = 1'b1;
    cyc();
    send_frame(1'b0, "reset_mem");
  endtask

  task automatic test_frame();
    drive_write(0, 24'h00CEFF); drive_write(1, 24'h112233);
    drive_write(2, 24'hABCDEF); drive_write(3, 24'hFF0000);
    drive_write(4, 24'($urandom));
    send_frame(1'b0, "frame_fixed");
    fill_random();
    send_frame(1'b0, "frame_rand");
  endtask

  task automatic test_gap_ignore();
    fill_random();
    send_frame(1'b1, "gap_ignore");
  endtask

  task automatic test_oob();
    for (int a = NUM; a < 8; a++) drive_write(a, 24'($urandom));
    send_frame(1'b0, "oob_write");
  endtask

  task automatic test_bypass();
    logic [23:0] exp_rgb;
    logic [23:0] d;
    int k;
    fill_random();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    pix_req = 1'b1; cyc(); pix_req = 1'b0;
    exp_rgb = model_mem[1];
    d = 24'($urandom);
    wr_en = 1'b1; wr_addr = IW'(1); wr_data = d; cyc(); wr_en = 1'b0;
    model_mem[1] = d;
    n_vec++;
    if (rgb !== exp_rgb) begin
      n_err++;
      $display("FAIL byp_current got rgb=%h exp %h", rgb, exp_rgb);
    end
    wr_en = 1'b1; wr_addr = IW'(2); wr_data = 24'h0F0F0F; pix_req = 1'b1;
    cyc();
    wr_en = 1'b0; pix_req = 1'b0;
    model_mem[2] = 24'h0F0F0F;
    n_vec++;
    if (rgb !== model_mem[2]) begin
      n_err++;
      $display("FAIL byp_next got rgb=%h exp %h", rgb, model_mem[2]);
    end
    drive_write(4, 24'($urandom));
    for (int p = 3; p < NUM; p++) begin
      pix_req = 1'b1; cyc(); pix_req = 1'b0;
      n_vec++;
      if (rgb !== model_mem[p]) begin
        n_err++;
        $display("FAIL byp_later%0d got rgb=%h exp %h", p, rgb, model_mem[p]);
      end
    end
    pix_req = 1'b1; cyc(); pix_req = 1'b0;
    k = 0;
    while (!frame_done && k < GAP + 20) begin cyc(); k++; end
    n_vec++;
    if (k != GAP) begin
      n_err++;
      $display("FAIL byp_done got %0d cycles exp %0d", k, GAP);
    end
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid();
    fill_random();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    repeat (2) begin pix_req = 1'b1; cyc(); pix_req = 1'b0; end
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if (rgb !== 24'h0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async got rgb=%h v=%b b=%b exp 0/0/0", rgb, pix_valid, busy);
    end
    cyc(); cyc();
    rst = 1'b1;
    for (int a = 0; a < NUM; a++) model_mem[a] = 24'h0;
    for (int i = 0; i < GAP + 5; i++) begin
      cyc();
      n_vec++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_abort got d=%b b=%b exp 0/0", frame_done, busy);
      end
    end
    send_frame(1'b0, "reset_mid_mem");
  endtask

  task automatic test_auto();
    int k;
    fill_random();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < NUM; p++) begin
        n_vec++;
        if (rgb !== model_mem[p] || pix_valid !== 1'b1 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL auto f%0d pix%0d got rgb=%h v=%b b=%b exp %h", f, p, rgb, pix_valid, busy, model_mem[p]);
        end
        repeat ($urandom_range(0, 3)) cyc();
        pix_req = 1'b1; cyc(); pix_req = 1'b0;
      end
      k = 0;
      while (!frame_done && k < GAP + 20) begin
        cyc();
        k++;
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL auto_busy f%0d got b=%b exp 1", f, busy);
        end
      end
      n_vec++;
      if (k != GAP || pix_valid !== 1'b1 || rgb !== model_mem[0]) begin
        n_err++;
        $display("FAIL auto_restart f%0d got k=%0d v=%b rgb=%h exp k=%0d v=1 rgb=%h", f, k, pix_valid, rgb, GAP, model_mem[0]);
      end
      cyc();
      n_vec++;
      if (frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL auto_pulse f%0d got d=%b exp 0", f, frame_done);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef AUTO_REFRESH_EN
    test_auto();
`else
    test_frame();
    test_gap_ignore();
    test_oob();
    test_bypass();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
